i2s_stream_tx: RTL and testbench



---
 rtl/i2s_stream_tx.sv | 161 ++++++++++++++++
 tb/tb_i2s_stream_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stream_tx.sv
// rtl/i2s_stream_tx.sv - I2S / left-justified stereo serializer with a frame FIFO and MCLK/BCLK/LRCK generation.
// Optional: define I2S_UNDERRUN_HOLD_EN to resend the previous frame on underrun instead of silence.
module i2s_stream_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 24,
  parameter int SCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int I2S_DELAY  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [SAMPLE_W-1:0]             s_left,
  input  logic [SAMPLE_W-1:0]             s_right,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            underrun,
  output logic                            aud_mclk,
  output logic                            aud_bclk,
  output logic                            aud_lrck,
  output logic                            aud_sdata
);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int FRM_W = 2*SAMPLE_W;
  localparam int PAD   = SLOT_W - SAMPLE_W - I2S_DELAY;

  typedef enum logic [1:0] {IDLE, RUN_L, RUN_R} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               mclk_q, mclk_d, bclk_q, bclk_d, lrck_q, lrck_d;
  logic               sdata_q, sdata_d, underrun_q, underrun_d;
  logic [FRM_W-1:0]   frame_q, frame_d, fill_frame, head;
  logic [SLOT_W-1:0]  shift_q, shift_d, load;
  logic [FRM_W-1:0]   mem_q [FIFO_DEPTH];
  logic [FRM_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               running, tick, fall, last_bit, frame_start, push, pop;

  // Sample placed in its slot, MSB first, after I2S_DELAY leading zero bits.
  function automatic logic [SLOT_W-1:0] align(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << PAD;
  endfunction

`ifdef I2S_UNDERRUN_HOLD_EN
  assign fill_frame = frame_q;
`else
  assign fill_frame = '0;
`endif

  assign s_ready    = !reset && (level_q != LVL_W'(FIFO_DEPTH));
  assign fifo_level = level_q;
  assign underrun   = underrun_q;
  assign aud_mclk   = mclk_q;
  assign aud_bclk   = bclk_q;
  assign aud_lrck   = lrck_q;
  assign aud_sdata  = sdata_q;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    running     = (state_q != IDLE) || enable;
    tick        = running && (div_q == DIV_W'(SCLK_DIV-1));
    fall        = tick && bclk_q;
    last_bit    = (bit_q == BIT_W'(SLOT_W-1));
    frame_start = fall && enable && ((state_q == IDLE) || ((state_q == RUN_R) && last_bit));
    pop         = frame_start && (level_q != '0);
    push        = s_valid && s_ready;

    mclk_d     = ~mclk_q;
    div_d      = (!running || tick) ? '0 : div_q + 1'b1;
    bclk_d     = running && (tick ? ~bclk_q : bclk_q);
    state_d    = state_q;
    bit_d      = bit_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    underrun_d = 1'b0;
    load       = '0;

    // Data and LRCK move only on falling BCLK so they are settled at the codec's rising edge.
    if (fall) begin
      if (frame_start) begin
        frame_d    = pop ? head : fill_frame;
        underrun_d = !pop;
        state_d    = RUN_L;
        bit_d      = '0;
        lrck_d     = 1'b0;
        load       = align(frame_d[FRM_W-1 -: SAMPLE_W]);
        sdata_d    = load[SLOT_W-1];
        shift_d    = load << 1;
      end else if ((state_q == RUN_L) && last_bit) begin
        state_d = RUN_R;
        bit_d   = '0;
        lrck_d  = 1'b1;
        load    = align(frame_q[SAMPLE_W-1:0]);
        sdata_d = load[SLOT_W-1];
        shift_d = load << 1;
      end else if ((state_q == RUN_R) && last_bit) begin
        state_d = IDLE;
        bit_d   = '0;
        lrck_d  = 1'b0;
        sdata_d = 1'b0;
        shift_d = '0;
      end else begin
        bit_d   = bit_q + 1'b1;
        sdata_d = shift_q[SLOT_W-1];
        shift_d = shift_q << 1;
      end
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {s_left, s_right};
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      mclk_q     <= 1'b0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      frame_q    <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      mclk_q     <= mclk_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_i2s_stream_tx.sv
// tb/tb_i2s_stream_tx.sv - self-checking bench for i2s_stream_tx against a frame-timing reference model.
`timescale 1ns/1ps
module tb_i2s_stream_tx;
  localparam int SW = 16, SL = 24, SD = 8, FD = 4, DL = 1;
  localparam int BITCLKS = 2*SD;
  localparam int FRAME   = 2*SL*BITCLKS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, s_valid, s_ready, underrun;
  logic [SW-1:0] s_left, s_right;
  logic [2:0] fifo_level;
  logic aud_mclk, aud_bclk, aud_lrck, aud_sdata;

  logic enable2, s_valid2, s_ready2, underrun2;
  logic [23:0] s_left2, s_right2;
  logic [2:0] fifo_level2;
  logic aud_mclk2, aud_bclk2, aud_lrck2, aud_sdata2;

  i2s_stream_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .SCLK_DIV(SD), .FIFO_DEPTH(FD), .I2S_DELAY(DL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .fifo_level(fifo_level), .underrun(underrun),
    .aud_mclk(aud_mclk), .aud_bclk(aud_bclk), .aud_lrck(aud_lrck), .aud_sdata(aud_sdata));

  i2s_stream_tx #(.SAMPLE_W(24), .SLOT_W(32), .SCLK_DIV(4), .FIFO_DEPTH(4), .I2S_DELAY(0)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_left(s_left2), .s_right(s_right2), .fifo_level(fifo_level2), .underrun(underrun2),
    .aud_mclk(aud_mclk2), .aud_bclk(aud_bclk2), .aud_lrck(aud_lrck2), .aud_sdata(aud_sdata2));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Slot capture as the codec would see it: one bit per rising BCLK, MSB = slot bit 0.
  logic pb1, pb2;
  logic [SL-1:0] cap_l, cap_r;
  logic [31:0] cap2_l, cap2_r;
  always @(negedge clk) begin
    if (aud_bclk && !pb1) begin
      if (aud_lrck) cap_r <= {cap_r[SL-2:0], aud_sdata};
      else          cap_l <= {cap_l[SL-2:0], aud_sdata};
    end
    if (aud_bclk2 && !pb2) begin
      if (aud_lrck2) cap2_r <= {cap2_r[30:0], aud_sdata2};
      else           cap2_l <= {cap2_l[30:0], aud_sdata2};
    end
    pb1 <= aud_bclk;
    pb2 <= aud_bclk2;
  end

  // Reference model: frame queue plus arithmetic position within the frame.
  logic [2*SW-1:0] mq[$];
  logic [2*SW-1:0] m_cur;
  int m_in, m_pre, m_fcnt;
  logic m_ur, m_mclk;

  function automatic logic exp_bit(input logic [SW-1:0] s, input int k);
    if (k >= DL && k < DL + SW) return s[SW-1-(k-DL)];
    return 1'b0;
  endfunction

  function automatic logic [SL-1:0] exp_slot(input logic [SW-1:0] s);
    logic [SL-1:0] v;
    v = '0;
    for (int k = 0; k < SL; k++) v[SL-1-k] = exp_bit(s, k);
    return v;
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic v,
                            input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic ready, start;
    if (rst) begin
      mq.delete();
      m_in = 0; m_pre = 0; m_fcnt = 0; m_cur = '0; m_ur = 1'b0; m_mclk = 1'b0;
      return;
    end
    ready  = (mq.size() < FD);
    m_mclk = ~m_mclk;
    m_ur   = 1'b0;
    start  = 1'b0;
    if (m_in != 0) begin
      m_fcnt++;
      if (m_fcnt == FRAME) begin
        if (en) begin start = 1'b1; m_fcnt = 0; end
        else begin m_in = 0; m_pre = 0; m_fcnt = 0; end
      end
    end else if (en) begin
      if (m_pre == BITCLKS-1) begin start = 1'b1; m_in = 1; m_fcnt = 0; end
      else m_pre++;
    end else begin
      m_pre = 0;
    end
    if (start) begin
      if (mq.size() > 0) m_cur = mq.pop_front();
      else begin
        m_ur = 1'b1;
`ifndef I2S_UNDERRUN_HOLD_EN
        m_cur = '0;
`endif
      end
    end
    if (v && ready) mq.push_back({l, r});
  endtask

  task automatic check_outputs();
    int j;
    logic [SW-1:0] smp;
    logic e_bclk, e_lr, e_sd;
    j      = m_fcnt / BITCLKS;
    e_bclk = (m_in != 0) ? ((m_fcnt % BITCLKS) >= SD) : (m_pre >= SD);
    e_lr   = (m_in != 0) && (j >= SL);
    smp    = (j >= SL) ? m_cur[SW-1:0] : m_cur[2*SW-1:SW];
    e_sd   = (m_in != 0) ? exp_bit(smp, j % SL) : 1'b0;
    check("s_ready",    s_ready,    !reset && (mq.size() < FD));
    check("fifo_level", fifo_level, mq.size());
    check("underrun",   underrun,   m_ur);
    check("aud_mclk",   aud_mclk,   m_mclk);
    check("aud_bclk",   aud_bclk,   e_bclk);
    check("aud_lrck",   aud_lrck,   e_lr);
    check("aud_sdata",  aud_sdata,  e_sd);
  endtask

  task automatic step(input logic rst, input logic en, input logic v,
                      input logic [SW-1:0] l, input logic [SW-1:0] r);
    reset = rst; enable = en; s_valid = v; s_left = l; s_right = r;
    model_edge(rst, en, v, l, r);
    @(negedge clk);
    check_outputs();
  endtask

  typedef struct {
    logic          v;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          exp_ready;
    logic [2:0]    exp_level;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int ur_cnt;
    logic en_r;
    tbl[0] = '{1'b1, 16'h1111, 16'h2222, 1'b1, 3'd1};
    tbl[1] = '{1'b1, 16'h3333, 16'h4444, 1'b1, 3'd2};
    tbl[2] = '{1'b1, 16'h5555, 16'h6666, 1'b1, 3'd3};
    tbl[3] = '{1'b1, 16'h7777, 16'h8888, 1'b0, 3'd4};
    tbl[4] = '{1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 3'd4};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4};
    enable2 = 1'b0; s_valid2 = 1'b0; s_left2 = '0; s_right2 = '0;
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    m_in = 0; m_pre = 0; m_fcnt = 0; m_cur = '0; m_ur = 1'b0; m_mclk = 1'b0;
    @(negedge clk);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0);
    check("rst_mclk", aud_mclk, 0);
    check("rst_bclk", aud_bclk, 0);
    check("rst_lrck", aud_lrck, 0);
    check("rst_sdata", aud_sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 0);

    // Single frame A5C3 / 0F0F, then disable so it parks after the frame.
    step(1'b0, 1'b0, 1'b1, 16'hA5C3, 16'h0F0F);
    check("t1_level", fifo_level, 1);
    repeat (BITCLKS + 10) step(1'b0, 1'b1, 1'b0, '0, '0);
    repeat (FRAME) step(1'b0, 1'b0, 1'b0, '0, '0);
    check("t1_left_slot", cap_l, 24'h52E180);
    check("t1_right_slot", cap_r, 24'h078780);

    // Fill while parked: fifth push is refused.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, tbl[i].v, tbl[i].l, tbl[i].r);
      check("tbl_ready", s_ready, tbl[i].exp_ready);
      check("tbl_level", fifo_level, tbl[i].exp_level);
    end
    repeat (BITCLKS) step(1'b0, 1'b1, 1'b0, '0, '0);
    for (int f = 0; f < 4; f++) begin
      repeat (FRAME) step(1'b0, (f != 3), 1'b0, '0, '0);
      check("tbl_frame_left", cap_l, exp_slot(tbl[f].l));
      check("tbl_frame_right", cap_r, exp_slot(tbl[f].r));
    end

    // Empty FIFO: one underrun pulse per frame start.
    ur_cnt = 0;
    repeat (BITCLKS + 2*FRAME) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if (underrun === 1'b1) ur_cnt++;
    end
    check("underrun_count", ur_cnt, 3);
    repeat (FRAME) step(1'b0, 1'b0, 1'b0, '0, '0);
`ifdef I2S_UNDERRUN_HOLD_EN
    check("underrun_left", cap_l, exp_slot(16'h7777));
`else
    check("underrun_left", cap_l, 24'h0);
`endif

    // Level 2 with a push on the frame-start edge.
    step(1'b0, 1'b0, 1'b1, 16'hA001, 16'hB001);
    step(1'b0, 1'b0, 1'b1, 16'hA002, 16'hB002);
    step(1'b0, 1'b0, 1'b1, 16'hA003, 16'hB003);
    repeat (BITCLKS) step(1'b0, 1'b1, 1'b0, '0, '0);
    check("t4_level_after_pop", fifo_level, 2);
    repeat (FRAME - 1) step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 16'hA004, 16'hB004);
    check("t4_level_push_pop", fifo_level, 2);
    repeat (FRAME) step(1'b0, 1'b0, 1'b0, '0, '0);
    check("t4_oldest_left", cap_l, exp_slot(16'hA002));
    check("t4_oldest_right", cap_r, exp_slot(16'hB002));

    // Reset at right slot bit 10.
    repeat (BITCLKS + (SL + 10)*BITCLKS + 3) step(1'b0, 1'b1, 1'b0, '0, '0);
    check("t5_pre_lrck", aud_lrck, 1);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    check("t5_mclk", aud_mclk, 0);
    check("t5_bclk", aud_bclk, 0);
    check("t5_lrck", aud_lrck, 0);
    check("t5_sdata", aud_sdata, 0);
    check("t5_level", fifo_level, 0);
    check("t5_ready", s_ready, 0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    check("t5_ready_release", s_ready, 1);
    step(1'b0, 1'b0, 1'b1, 16'h8001, 16'h7FFE);
    repeat (BITCLKS) step(1'b0, 1'b1, 1'b0, '0, '0);
    check("t5_fresh_lrck", aud_lrck, 0);
    repeat (FRAME) step(1'b0, 1'b0, 1'b0, '0, '0);
    check("t5_fresh_left", cap_l, exp_slot(16'h8001));
    check("t5_fresh_right", cap_r, exp_slot(16'h7FFE));

    // Left-justified 24-in-32 instance.
    s_valid2 = 1'b1; s_left2 = 24'h800001; s_right2 = 24'h0;
    step(1'b0, 1'b0, 1'b0, '0, '0);
    s_valid2 = 1'b0;
    check("lj_level", fifo_level2, 1);
    enable2 = 1'b1;
    repeat (10) step(1'b0, 1'b0, 1'b0, '0, '0);
    enable2 = 1'b0;
    repeat (2*32*8) step(1'b0, 1'b0, 1'b0, '0, '0);
    check("lj_left_slot", cap2_l, 32'h80000100);
    check("lj_right_slot", cap2_r, 32'h0);
    check("lj_level_after", fifo_level2, 0);

    // Random traffic with occasional enable toggles.
    en_r = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 1499) == 0) en_r = ~en_r;
      step(1'b0, en_r, ($urandom_range(0, 299) == 0),
           SW'($urandom), SW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
